// File: rtl/axicb_pkg.sv
// Shared crossbar helpers: index width and lowest-set-bit one-hot decode.
package axicb_pkg;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Lowest set bit wins so a multi-hot grant still yields a single owner.
   function automatic int oh2idx(input logic [15:0] v);
      int r;
      r = 0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/axicb_order_fifo.sv
// In-order tracking FIFO of requester indices with full/empty/count derived
// from pointers that carry an extra wrap bit.
module axicb_order_fifo
   import axicb_pkg::*;
#(
   parameter int W     = 2,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     srst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_din,
   input  logic                     i_pop,
   output logic [W-1:0]             o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_empty   = (r_wptr == r_rptr);
   assign o_count   = r_wptr - r_rptr;
   assign o_dout    = r_mem[r_rptr[AW-1:0]];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (srst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/axicb_resp_router.sv
// Steers slave responses to the requester owning the oldest outstanding grant.
// Optional watchdog enabled by defining AXICB_RESP_TIMEOUT_EN.
module axicb_resp_router
   import axicb_pkg::*;
#(
   parameter int REQ_NB         = 4,
   parameter int DEPTH          = 8,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     srst,
   input  logic                     grant_valid,
   input  logic [REQ_NB-1:0]        grant,
   output logic                     grant_ready,
   input  logic                     rsp_valid,
   output logic                     rsp_ready,
   input  logic [DATA_W-1:0]        rsp_data,
   input  logic                     rsp_last,
   output logic [REQ_NB-1:0]        m_rvalid,
   input  logic [REQ_NB-1:0]        m_rready,
   output logic [DATA_W-1:0]        m_rdata,
   output logic                     m_rlast,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     timeout_err
);
   localparam int IDX_W = idx_width(REQ_NB);

   logic [15:0]       w_grant_ext;
   logic [IDX_W-1:0]  w_push_idx;
   logic [IDX_W-1:0]  w_head;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;

   always_comb begin
      w_grant_ext = '0;
      w_grant_ext[REQ_NB-1:0] = grant;
   end

   assign w_push_idx  = IDX_W'(oh2idx(w_grant_ext));
   assign w_push      = grant_valid & ~w_full & (|grant);
   assign grant_ready = ~w_full;
   assign w_pop       = rsp_valid & rsp_ready & rsp_last;
   assign m_rdata     = rsp_data;
   assign m_rlast     = rsp_last;

   axicb_order_fifo #(.W(IDX_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .srst    (srst),
      .i_push  (w_push),
      .i_din   (w_push_idx),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (outstanding)
   );

   // Responses are only routed once an owner exists; nothing is bypassed.
   always_comb begin
      m_rvalid  = '0;
      rsp_ready = 1'b0;
      if (!w_empty) begin
         m_rvalid[w_head] = rsp_valid;
         rsp_ready        = m_rready[w_head];
      end else begin
         m_rvalid  = '0;
         rsp_ready = 1'b0;
      end
   end

`ifdef AXICB_RESP_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_err;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_empty || (rsp_valid && rsp_ready)) begin
         w_cnt_nxt = '0;
      end else if (r_cnt != CW'(TIMEOUT_CYCLES)) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (srst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_err <= r_err | (w_cnt_nxt == CW'(TIMEOUT_CYCLES));
      end
   end

   assign timeout_err = r_err;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_resp_router.sv
// Directed-vector bench for axicb_resp_router (REQ_NB=4, DEPTH=8, timeout 16).
module tb_axicb_resp_router;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic        srst;
   logic        grant_valid;
   logic [3:0]  grant;
   logic        grant_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic [3:0]  m_rvalid;
   logic [3:0]  m_rready;
   logic [31:0] m_rdata;
   logic        m_rlast;
   logic [3:0]  outstanding;
   logic        timeout_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   axicb_resp_router #(.REQ_NB(4), .DEPTH(8), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .aclk(aclk), .aresetn(aresetn), .srst(srst),
      .grant_valid(grant_valid), .grant(grant), .grant_ready(grant_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_rdata(m_rdata), .m_rlast(m_rlast), .outstanding(outstanding),
      .timeout_err(timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic push(input logic [3:0] g);
      grant_valid = 1'b1;
      grant       = g;
      step();
      grant_valid = 1'b0;
      grant       = 4'b0000;
   endtask

   task automatic beat(input logic [31:0] d, input logic last, input logic [3:0] exp_v, input string tag);
      rsp_valid = 1'b1;
      rsp_data  = d;
      rsp_last  = last;
      #1;
      check({tag, "_rvalid"}, {28'd0, m_rvalid}, {28'd0, exp_v});
      check({tag, "_rdata"}, m_rdata, d);
      check({tag, "_rready"}, {31'd0, rsp_ready}, 32'd1);
      step();
      rsp_valid = 1'b0;
      rsp_last  = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_oh;
      aresetn = 1'b0; srst = 1'b0; grant_valid = 1'b0; grant = 4'b0000;
      rsp_valid = 1'b0; rsp_data = 32'd0; rsp_last = 1'b0; m_rready = 4'b1111;
      repeat (3) step();
      aresetn = 1'b1;
      step();
      check("rst_grant_ready", {31'd0, grant_ready}, 32'd1);
      check("rst_rsp_ready", {31'd0, rsp_ready}, 32'd0);
      check("rst_outstanding", {28'd0, outstanding}, 32'd0);
      check("rst_m_rvalid", {28'd0, m_rvalid}, 32'd0);
      check("rst_timeout", {31'd0, timeout_err}, 32'd0);

      // In-order routing
      push(4'b0010); push(4'b1000); push(4'b0001);
      check("ord_outstanding3", {28'd0, outstanding}, 32'd3);
      beat(32'hD000_0000, 1'b1, 4'b0010, "ord0");
      beat(32'hD000_0001, 1'b1, 4'b1000, "ord1");
      beat(32'hD000_0002, 1'b1, 4'b0001, "ord2");
      check("ord_outstanding0", {28'd0, outstanding}, 32'd0);

      // Burst with requester back-pressure
      push(4'b0100);
      m_rready = 4'b0100;
      beat(32'hB0, 1'b0, 4'b0100, "bst0");
      rsp_valid = 1'b1; rsp_data = 32'hB1; rsp_last = 1'b0; m_rready = 4'b0000;
      #1;
      check("bst_stall_ready", {31'd0, rsp_ready}, 32'd0);
      check("bst_stall_rvalid", {28'd0, m_rvalid}, 32'd4);
      step(); step();
      m_rready = 4'b0100;
      beat(32'hB1, 1'b0, 4'b0100, "bst1");
      beat(32'hB2, 1'b0, 4'b0100, "bst2");
      check("bst_mid_outstanding", {28'd0, outstanding}, 32'd1);
      beat(32'hB3, 1'b1, 4'b0100, "bst3");
      check("bst_outstanding0", {28'd0, outstanding}, 32'd0);
      m_rready = 4'b1111;

      // Fill to full, refused 9th grant, then push+pop at full
      for (int i = 0; i < 8; i++) push(4'b0001 << (i % 4));
      check("full_grant_ready", {31'd0, grant_ready}, 32'd0);
      check("full_outstanding", {28'd0, outstanding}, 32'd8);
      push(4'b0001);
      check("full_9th_ignored", {28'd0, outstanding}, 32'd8);
      grant_valid = 1'b1; grant = 4'b0001;
      beat(32'hF0, 1'b1, 4'b0001, "full_pp");
      grant_valid = 1'b0; grant = 4'b0000;
      check("full_pp_outstanding", {28'd0, outstanding}, 32'd7);
      check("full_pp_grant_ready", {31'd0, grant_ready}, 32'd1);
      for (int i = 1; i < 8; i++) begin
         exp_oh = 4'b0001 << (i % 4);
         beat(32'hF0 + i, 1'b1, exp_oh, "drain");
      end
      check("drain_outstanding", {28'd0, outstanding}, 32'd0);

      // Edge cases
      push(4'b0000);
      check("zero_grant", {28'd0, outstanding}, 32'd0);
      grant_valid = 1'b1; grant = 4'b0110; rsp_valid = 1'b1; rsp_last = 1'b1;
      #1;
      check("empty_rsp_ready", {31'd0, rsp_ready}, 32'd0);
      check("empty_m_rvalid", {28'd0, m_rvalid}, 32'd0);
      step();
      grant_valid = 1'b0; grant = 4'b0000;
      check("multihot_outstanding", {28'd0, outstanding}, 32'd1);
      beat(32'h61, 1'b1, 4'b0010, "multihot");
      check("multihot_drained", {28'd0, outstanding}, 32'd0);

      // Synchronous reset flushes
      push(4'b1000); push(4'b0100);
      srst = 1'b1; step(); srst = 1'b0;
      check("srst_outstanding", {28'd0, outstanding}, 32'd0);
      check("srst_grant_ready", {31'd0, grant_ready}, 32'd1);

`ifdef AXICB_RESP_TIMEOUT_EN
      push(4'b0001);
      repeat (15) step();
      check("to_before", {31'd0, timeout_err}, 32'd0);
      step();
      check("to_set", {31'd0, timeout_err}, 32'd1);
      beat(32'h70, 1'b1, 4'b0001, "to_rsp");
      check("to_sticky", {31'd0, timeout_err}, 32'd1);
      srst = 1'b1; step(); srst = 1'b0;
      check("to_srst_clear", {31'd0, timeout_err}, 32'd0);
`else
      push(4'b0001);
      repeat (20) step();
      check("to_disabled", {31'd0, timeout_err}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
